// File: rtl/flash_reader.sv
// rtl/flash_reader.sv - SB_SPI register-bus sequencer issuing flash READ (0x03) into a byte stream
//
// Optional feature macro: FLASH_WAKE_EN (deep power-down release 0xAB after init,
// followed by a WAKE_CYCLES settle wait; WAKE_CYCLES exists only in that build).
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             start a read (sampled only while o_busy=0)
//   i_faddr[23:0]       flash byte address
//   i_count[7:0]        bytes to read, 0 means 256
//   o_busy              init or transaction in progress
//   o_valid, o_byte     data byte stream toward the consumer
//   i_ready             consumer accepts o_byte when o_valid & i_ready
//   o_done              one-cycle pulse after chip select release
//   o_en, o_wr, o_addr, o_wdata   register bus request to the SPI wrapper
//   i_ack, i_rdata      register bus acknowledge and read data

module flash_reader #(
  parameter int         CLK_FREQ   = 48_000_000,
  parameter int         SCLK_FREQ  = 3_000_000,
  parameter logic [7:0] CS_ASSERT  = 8'h0E,
  parameter logic [7:0] CS_RELEASE = 8'h0F
`ifdef FLASH_WAKE_EN
  ,
  parameter int         WAKE_CYCLES = 1_000
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [23:0] i_faddr,
  input  logic [7:0]  i_count,
  output logic        o_busy,
  output logic        o_valid,
  output logic [7:0]  o_byte,
  input  logic        i_ready,
  output logic        o_done,
  output logic        o_en,
  output logic        o_wr,
  output logic [3:0]  o_addr,
  output logic [7:0]  o_wdata,
  input  logic        i_ack,
  input  logic [7:0]  i_rdata
);

  // SPI baud rate divider programmed into SPIBR.
  localparam logic [7:0] BR = 8'(CLK_FREQ / SCLK_FREQ - 1);

  // SB_SPI register map.
  localparam logic [3:0] A_CR1  = 4'h9;
  localparam logic [3:0] A_CR2  = 4'hA;
  localparam logic [3:0] A_BR   = 4'hB;
  localparam logic [3:0] A_SR   = 4'hC;
  localparam logic [3:0] A_TXDR = 4'hD;
  localparam logic [3:0] A_RXDR = 4'hE;
  localparam logic [3:0] A_CSR  = 4'hF;

  // SPISR bits.
  localparam int SR_TIP  = 7;
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;

  // Sequencer states. An XFER is the chain TPOLL -> TX -> RPOLL -> RX.
  localparam logic [3:0] ST_INIT  = 4'd0;   // four controller setup writes
  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_CSA   = 4'd2;   // assert chip select
  localparam logic [3:0] ST_TPOLL = 4'd3;   // poll SPISR for TRDY
  localparam logic [3:0] ST_TX    = 4'd4;   // write SPITXDR
  localparam logic [3:0] ST_RPOLL = 4'd5;   // poll SPISR for RRDY
  localparam logic [3:0] ST_RX    = 4'd6;   // read SPIRXDR
  localparam logic [3:0] ST_HOLD  = 4'd7;   // byte presented, waiting for consumer
  localparam logic [3:0] ST_EPOLL = 4'd8;   // poll SPISR until TIP clears
  localparam logic [3:0] ST_ECS   = 4'd9;   // release chip select
  localparam logic [3:0] ST_WAIT  = 4'd10;  // post-wake settle time

  // What the current XFER belongs to; decides the TX byte and where RX goes.
  localparam logic [1:0] PH_CMD  = 2'd0;
  localparam logic [1:0] PH_DATA = 2'd1;
  localparam logic [1:0] PH_WAKE = 2'd2;

  logic [3:0]  state;
  logic [1:0]  phase;
  logic [1:0]  idx;        // init write index, or command byte index
  logic [23:0] faddr;
  logic [8:0]  cnt;        // bytes still to deliver, 1..256

`ifdef FLASH_WAKE_EN
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  logic [WAKE_W-1:0] wake_cnt;
`endif

  // Register access the current state wants to perform.
  logic       acc_req;
  logic       acc_wr;
  logic [3:0] acc_addr;
  logic [7:0] acc_wdata;
  logic [7:0] tx_byte;

  assign o_busy = (state != ST_IDLE);

  always_comb begin
    tx_byte = 8'h00;
    case (phase)
      PH_CMD: begin
        case (idx)
          2'd0:    tx_byte = 8'h03;
          2'd1:    tx_byte = faddr[23:16];
          2'd2:    tx_byte = faddr[15:8];
          default: tx_byte = faddr[7:0];
        endcase
      end
      PH_WAKE: tx_byte = 8'hAB;
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    acc_req   = 1'b1;
    acc_wr    = 1'b0;
    acc_addr  = A_SR;
    acc_wdata = 8'h00;
    case (state)
      ST_INIT: begin
        acc_wr = 1'b1;
        case (idx)
          2'd0:    begin acc_addr = A_CR1; acc_wdata = 8'h80;      end
          2'd1:    begin acc_addr = A_CR2; acc_wdata = 8'hC0;      end
          2'd2:    begin acc_addr = A_BR;  acc_wdata = BR;         end
          default: begin acc_addr = A_CSR; acc_wdata = CS_RELEASE; end
        endcase
      end
      ST_CSA: begin
        acc_wr    = 1'b1;
        acc_addr  = A_CSR;
        acc_wdata = CS_ASSERT;
      end
      ST_TPOLL, ST_RPOLL, ST_EPOLL: begin
        acc_addr = A_SR;
      end
      ST_TX: begin
        acc_wr    = 1'b1;
        acc_addr  = A_TXDR;
        acc_wdata = tx_byte;
      end
      ST_RX: begin
        acc_addr = A_RXDR;
      end
      ST_ECS: begin
        acc_wr    = 1'b1;
        acc_addr  = A_CSR;
        acc_wdata = CS_RELEASE;
      end
      default: acc_req = 1'b0;
    endcase
  end

  // The bus request registers are loaded only while o_en is low and cleared
  // on the ack edge, so a new request always sees one idle cycle of o_en and
  // the request fields cannot change while an access is outstanding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_INIT;
      phase   <= PH_CMD;
      idx     <= 2'd0;
      faddr   <= 24'h0;
      cnt     <= 9'd0;
      o_valid <= 1'b0;
      o_byte  <= 8'h00;
      o_done  <= 1'b0;
      o_en    <= 1'b0;
      o_wr    <= 1'b0;
      o_addr  <= 4'h0;
      o_wdata <= 8'h00;
`ifdef FLASH_WAKE_EN
      wake_cnt <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      if (o_en) begin
        if (i_ack) begin
          o_en <= 1'b0;
          case (state)
            ST_INIT: begin
              if (idx == 2'd3) begin
                idx <= 2'd0;
`ifdef FLASH_WAKE_EN
                phase <= PH_WAKE;
                state <= ST_CSA;
`else
                state <= ST_IDLE;
`endif
              end else begin
                idx <= idx + 2'd1;
              end
            end
            ST_CSA:   state <= ST_TPOLL;
            ST_TPOLL: if (i_rdata[SR_TRDY]) state <= ST_TX;
            ST_TX:    state <= ST_RPOLL;
            ST_RPOLL: if (i_rdata[SR_RRDY]) state <= ST_RX;
            ST_RX: begin
              case (phase)
                PH_CMD: begin
                  // Command and address echo bytes are read only to drain RXDR.
                  if (idx == 2'd3) begin
                    idx   <= 2'd0;
                    phase <= PH_DATA;
                  end else begin
                    idx <= idx + 2'd1;
                  end
                  state <= ST_TPOLL;
                end
                PH_DATA: begin
                  o_byte  <= i_rdata;
                  o_valid <= 1'b1;
                  state   <= ST_HOLD;
                end
                default: state <= ST_EPOLL;
              endcase
            end
            ST_EPOLL: if (!i_rdata[SR_TIP]) state <= ST_ECS;
            ST_ECS: begin
`ifdef FLASH_WAKE_EN
              if (phase == PH_WAKE) begin
                phase    <= PH_CMD;
                wake_cnt <= '0;
                state    <= ST_WAIT;
              end else begin
                o_done <= 1'b1;
                state  <= ST_IDLE;
              end
`else
              o_done <= 1'b1;
              state  <= ST_IDLE;
`endif
            end
            default: state <= state;
          endcase
        end
      end else if (acc_req) begin
        o_en    <= 1'b1;
        o_wr    <= acc_wr;
        o_addr  <= acc_addr;
        o_wdata <= acc_wdata;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              faddr <= i_faddr;
              cnt   <= (i_count == 8'd0) ? 9'd256 : {1'b0, i_count};
              phase <= PH_CMD;
              idx   <= 2'd0;
              state <= ST_CSA;
            end
          end
          // No register access is issued from here, so a stalled consumer
          // never lets the controller overrun RXDR.
          ST_HOLD: begin
            if (i_ready) begin
              o_valid <= 1'b0;
              cnt     <= cnt - 9'd1;
              state   <= (cnt == 9'd1) ? ST_EPOLL : ST_TPOLL;
            end
          end
`ifdef FLASH_WAKE_EN
          ST_WAIT: begin
            if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) state <= ST_IDLE;
            else wake_cnt <= wake_cnt + 1'b1;
          end
`endif
          default: state <= state;
        endcase
      end
    end
  end

endmodule
